// File: rtl/coin_input_conditioner.sv
// Coin button front end: a 2-flop synchronizer and a debouncer on each input, feeding a
// lockout FSM that emits one pulse per accepted coin, or err when presses collide.
module coin_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nc5,
    input  logic       nc10,
    input  logic       nc20,
    output logic       c5,
    output logic       c10,
    output logic       c20,
    output logic [4:0] coin_value,
    output logic       err,
    output logic       busy
);

    localparam logic [7:0] LP_D = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] LP_L = 8'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StLock, StWaitRel} state_t;

    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_deb;
    logic [7:0] r_cnt [3];
    logic [2:0] w_press;
    logic [1:0] w_npress;
    logic       w_all_rel;
    state_t     r_state;
    logic [7:0] r_lock_cnt;

    // Bit 0 = 5, bit 1 = 10, bit 2 = 20; all active-low.
    assign w_raw = {nc20, nc10, nc5};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_cnt[i] == LP_D) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else if (r_sync2[i] != r_deb[i]) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // A press is the cycle a released level is about to flip to pressed.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_press[i] = (r_cnt[i] == LP_D) && r_deb[i];
        end
    end

    assign w_npress  = {1'b0, w_press[0]} + {1'b0, w_press[1]} + {1'b0, w_press[2]};
    assign w_all_rel = &r_deb;
    assign busy      = (r_state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_lock_cnt <= '0;
            c5         <= 1'b0;
            c10        <= 1'b0;
            c20        <= 1'b0;
            err        <= 1'b0;
            coin_value <= '0;
        end else begin
            c5         <= 1'b0;
            c10        <= 1'b0;
            c20        <= 1'b0;
            err        <= 1'b0;
            coin_value <= '0;
            case (r_state)
                StIdle: begin
                    if (w_npress == 2'd1) begin
                        c5         <= w_press[0];
                        c10        <= w_press[1];
                        c20        <= w_press[2];
                        coin_value <= w_press[0] ? 5'd5 : (w_press[1] ? 5'd10 : 5'd20);
                        r_lock_cnt <= LP_L;
                        r_state    <= StLock;
                    end else if (w_npress > 2'd1) begin
                        err     <= 1'b1;
                        r_state <= StWaitRel;
                    end
                end
                StLock: begin
                    if (r_lock_cnt <= 8'd1) begin
                        r_lock_cnt <= '0;
                        r_state    <= StWaitRel;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 8'd1;
                    end
                end
                StWaitRel: begin
                    if (w_all_rel) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner (D=4, L=8): stimulus pushes expected pulses
// into a scoreboard; a negedge monitor pops and checks them as the DUT emits them.
module tb_coin_input_conditioner;

    localparam int D = 4;
    localparam int L = 8;
    localparam int KERR = 31;

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       nc5;
    logic       nc10;
    logic       nc20;
    logic       c5;
    logic       c10;
    logic       c20;
    logic [4:0] coin_value;
    logic       err;
    logic       busy;

    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nc5       (nc5),
        .nc10      (nc10),
        .nc20      (nc20),
        .c5        (c5),
        .c10       (c10),
        .c20       (c20),
        .coin_value(coin_value),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    initial begin
        int   n_act;
        int   kind;
        int   exp_cv;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_pulse: got none by cyc %0d, required kind %0d at cyc %0d",
                             cyc, sb[0].kind, sb[0].cyc);
                    void'(sb.pop_front());
                end
                n_act = int'(c5) + int'(c10) + int'(c20) + int'(err);
                if (n_act > 0) begin
                    total++;
                    if (n_act > 1) begin
                        bad++;
                        $display("FAIL onehot: got %0d active outputs at cyc %0d, required 1",
                                 n_act, cyc);
                    end
                    kind = c5 ? 5 : (c10 ? 10 : (c20 ? 20 : KERR));
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: got kind %0d at cyc %0d, required none",
                                 kind, cyc);
                    end else begin
                        e = sb.pop_front();
                        total++;
                        if (e.cyc != cyc || e.kind != kind) begin
                            bad++;
                            $display("FAIL pulse: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                                     kind, cyc, e.kind, e.cyc);
                        end
                        exp_cv = (e.kind == KERR) ? 0 : e.kind;
                        total++;
                        if (int'(coin_value) != exp_cv) begin
                            bad++;
                            $display("FAIL coin_value: got %0d at cyc %0d, required %0d",
                                     coin_value, cyc, exp_cv);
                        end
                    end
                end else begin
                    total++;
                    if (coin_value != 5'd0) begin
                        bad++;
                        $display("FAIL idle_value: got %0d at cyc %0d, required 0", coin_value, cyc);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk_busy(input string name, input logic req);
        total++;
        if (busy !== req) begin
            bad++;
            $display("FAIL %s: busy got %b at cyc %0d, required %b", name, busy, cyc, req);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_busy(name, 1'b0);
    endtask

    task automatic push(input int c, input int k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    initial begin
        int k;
        int m;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        nc5   = 1'b1;
        nc10  = 1'b1;
        nc20  = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({c5, c10, c20, err, coin_value, busy} !== 10'd0) begin
            bad++;
            $display("FAIL reset_state: got %b, required all zero",
                     {c5, c10, c20, err, coin_value, busy});
        end
        rst = 1'b0;

        // Clean held press of 10
        k = cyc + 10;
        wait_cyc(k - 1);
        nc10 = 1'b0;
        push(k + D + 2, 10);
        wait_cyc(k + D + 3);
        chk_busy("a_busy_lock", 1'b1);
        wait_cyc(k + 39);
        nc10 = 1'b1;
        wait_cyc(k + 40 + D + 2);
        chk_busy("a_busy_rel_pending", 1'b1);
        wait_cyc(k + 40 + D + 3);
        chk_busy("a_busy_released", 1'b0);

        // Bounce on nc5 shorter than D: nothing may happen
        k = cyc + 3;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(k - 1 + 2 * i);
            nc5 = (i % 2 == 0) ? 1'b0 : 1'b1;
            chk_busy("b_bounce_busy", 1'b0);
        end
        nc5 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(k + 20 + i);
            chk_busy("b_after_busy", 1'b0);
        end

        // Simultaneous 5 and 20 -> err
        k = cyc + 5;
        wait_cyc(k - 1);
        nc5  = 1'b0;
        nc20 = 1'b0;
        push(k + D + 2, KERR);
        wait_cyc(k + D + 3);
        chk_busy("c_busy_err", 1'b1);
        wait_cyc(k + 9);
        nc5 = 1'b1;
        wait_cyc(k + 14);
        nc20 = 1'b1;
        wait_cyc(k + 15 + D + 2);
        chk_busy("c_busy_wait", 1'b1);
        wait_cyc(k + 15 + D + 3);
        chk_busy("c_busy_done", 1'b0);

        // 20 accepted, 5 pressed during lockout and held past it
        k = cyc + 5;
        wait_cyc(k - 1);
        nc20 = 1'b0;
        push(k + D + 2, 20);
        wait_cyc(k + 2);
        nc5 = 1'b0;
        wait_cyc(k + 19);
        nc20 = 1'b1;
        wait_cyc(k + 30);
        chk_busy("d_busy_held", 1'b1);
        wait_cyc(k + 39);
        nc5 = 1'b1;
        wait_cyc(k + 40 + D + 2);
        chk_busy("d_busy_wait", 1'b1);
        wait_cyc(k + 40 + D + 3);
        chk_busy("d_busy_done", 1'b0);

        // Reset while c10 is high; held button re-accepted after release
        k = cyc + 5;
        wait_cyc(k - 1);
        nc10 = 1'b0;
        push(k + D + 2, 10);
        wait_cyc(k + D + 2);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({c10, busy, coin_value} !== 7'd0) begin
            bad++;
            $display("FAIL reset_midpulse: got c10=%b busy=%b value=%0d, required 0 0 0",
                     c10, busy, coin_value);
        end
        m = k + 10;
        wait_cyc(m);
        rst = 1'b0;
        push(m + 1 + D + 2, 10);
        wait_cyc(m + 20);
        nc10 = 1'b1;
        wait_idle("e_idle");

        // Three clean sequential presses 5, 10, 20
        k = cyc + 5;
        wait_cyc(k - 1);
        nc5 = 1'b0;
        push(k + D + 2, 5);
        wait_cyc(k + 9);
        nc5 = 1'b1;
        wait_cyc(k + 19);
        nc10 = 1'b0;
        push(k + 20 + D + 2, 10);
        wait_cyc(k + 29);
        nc10 = 1'b1;
        wait_cyc(k + 39);
        nc20 = 1'b0;
        push(k + 40 + D + 2, 20);
        wait_cyc(k + 49);
        nc20 = 1'b1;
        wait_idle("f_idle");

        wait_cyc(cyc + 20);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
